// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: turns load/store control into a request/ready
// bus transaction, stalls the pipeline until it completes and records access errors.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [31:0]       ALUresultM,
    input  logic [31:0]       WriteDataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              misalign,
    output logic              bus_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_load;
    logic             acc;
    logic             aligned;

    assign is_load = (ResultSrcM == 2'b01);
    assign acc     = MemWriteM | is_load;
    assign aligned = (ALUresultM[1:0] == 2'b00);

    // Combinational so the stall lands in the same cycle the access reaches MEM.
    assign StallM  = ((state == IDLE) && acc) || (state == REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadDataM <= '0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            // Clear first so a set event later in this block takes priority.
            if (err_clr) begin
                misalign <= 1'b0;
                bus_err  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (acc) begin
                        if (aligned) begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWriteM;
                            mem_addr  <= {ALUresultM[ADDR_W-1:2], 2'b00};
                            mem_wdata <= WriteDataM;
                            cnt       <= '0;
                        end else begin
                            state     <= DONE;
                            misalign  <= 1'b1;
                            ReadDataM <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (!mem_we) begin
                            ReadDataM <= mem_rdata;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        bus_err   <= 1'b1;
                        ReadDataM <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Unstalled advance cycle; the instruction leaves MEM here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios plus random accesses checked
// against a transaction-level model of stall length, bus requests and result data.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUresultM;
    logic [31:0] WriteDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        misalign;
    logic        bus_err;
    logic        err_clr;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_rd;
    logic        m_mis;
    logic        m_berr;

    dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUresultM(ALUresultM), .WriteDataM(WriteDataM), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
        .StallM(StallM), .misalign(misalign), .bus_err(bus_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        mem_ready  = 1'b0;
        err_clr    = 1'b0;
    endtask

    // One instruction through MEM; lat = REQ cycle on which ready comes (0 = never).
    task automatic run_access(input string tag, input logic we, input logic ld,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int lat, input logic clr);
        int         stall_n = 0;
        int         req_n   = 0;
        int         exp_stall;
        int         exp_req;
        logic       bus_bad = 1'b0;
        bit         done    = 1'b0;
        logic [1:0] rs;

        if (clr) begin
            m_mis  = 1'b0;
            m_berr = 1'b0;
        end
        if (!(we || ld)) begin
            exp_stall = 0;
            exp_req   = 0;
        end else if (addr[1:0] != 2'b00) begin
            exp_stall = 1;
            exp_req   = 0;
            m_mis     = 1'b1;
            m_rd      = 32'h0;
        end else if (lat < 1 || lat > TIMEOUT) begin
            exp_req   = TIMEOUT;
            exp_stall = TIMEOUT + 1;
            m_berr    = 1'b1;
            m_rd      = 32'h0;
        end else begin
            exp_req   = lat;
            exp_stall = lat + 1;
            if (!we) m_rd = rd;
        end

        rs = 2'($urandom_range(0, 3));
        if (rs == 2'b01) rs = 2'b10;
        MemWriteM  = we;
        ResultSrcM = ld ? 2'b01 : rs;
        ALUresultM = addr;
        WriteDataM = wd;
        err_clr    = clr;
        mem_ready  = 1'b0;

        for (int c = 0; c < TIMEOUT + 8 && !done; c++) begin
            #2;
            if (StallM) stall_n++;
            else        done = 1'b1;
            if (mem_req) begin
                req_n++;
                if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== we || mem_wdata !== wd)
                    bus_bad = 1'b1;
            end
            mem_ready = mem_req ? (req_n == lat) : 1'($urandom_range(0, 1));
            mem_rdata = (mem_req && mem_ready) ? rd : $urandom;
            if (done) chk({tag, ".rdata"}, ReadDataM, m_rd);
            tick;
            err_clr = 1'b0;
        end
        drive_nop;
        #2;
        chk({tag, ".stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        chk({tag, ".req_cycles"}, 32'(req_n), 32'(exp_req));
        chk({tag, ".bus_fields"}, {31'h0, bus_bad}, 32'h0);
        chk({tag, ".misalign"}, {31'h0, misalign}, {31'h0, m_mis});
        chk({tag, ".bus_err"}, {31'h0, bus_err}, {31'h0, m_berr});
        chk({tag, ".idle_req"}, {31'h0, mem_req}, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        drive_nop;
        ALUresultM = 32'h0;
        WriteDataM = 32'h0;
        mem_rdata  = 32'h0;
        m_rd       = 32'h0;
        m_mis      = 1'b0;
        m_berr     = 1'b0;
        tick;
        tick;
        chk("reset.mem_req", {31'h0, mem_req}, 32'h0);
        chk("reset.mem_addr", mem_addr, 32'h0);
        chk("reset.ReadDataM", ReadDataM, 32'h0);
        chk("reset.flags", {30'h0, misalign, bus_err}, 32'h0);
        chk("reset.StallM", {31'h0, StallM}, 32'h0);
        rst = 1'b0;
        tick;

        run_access("load_wait2", 1'b0, 1'b1, 32'h0000_0010, 32'hAAAA_0000, 32'hDEAD_BEEF, 2, 1'b0);
        run_access("store_imm", 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h5555_5555, 1, 1'b0);
        run_access("load_misal", 1'b0, 1'b1, 32'h0000_0013, 32'h0, 32'h7777_7777, 1, 1'b0);
        run_access("err_clr", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 1'b1);
        run_access("load_timeout", 1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'h9999_9999, 0, 1'b0);
        run_access("store_misal_clr", 1'b1, 1'b0, 32'h0000_0042, 32'h1, 32'h0, 1, 1'b1);
        run_access("clr_all", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1, 1'b1);
        run_access("load_prime", 1'b0, 1'b1, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1, 1'b0);

        // Reset pulsed during the second REQ cycle of a load.
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b01;
        ALUresultM = 32'h0000_0040;
        mem_ready  = 1'b0;
        tick;
        tick;
        #2;
        chk("midreq.req_before", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midreq.mem_req", {31'h0, mem_req}, 32'h0);
        chk("midreq.outputs", mem_addr | mem_wdata | {31'h0, mem_we}, 32'h0);
        chk("midreq.ReadDataM", ReadDataM, 32'h0);
        chk("midreq.stall_follows_acc", {31'h0, StallM}, 32'h1);
        drive_nop;
        #1;
        chk("midreq.stall_nop", {31'h0, StallM}, 32'h0);
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick;
        #2;
        chk("midreq.ready_ignored", ReadDataM, 32'h0);
        chk("midreq.no_req", {31'h0, mem_req}, 32'h0);
        m_rd   = 32'h0;
        m_mis  = 1'b0;
        m_berr = 1'b0;
        mem_ready = 1'b0;
        tick;

        run_access("b2b_alu", 1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 1, 1'b0);
        run_access("b2b_load", 1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'h0BAD_CAFE, 1, 1'b0);
        run_access("b2b_store", 1'b1, 1'b0, 32'h0000_0204, 32'h0F0F_0F0F, 32'h0, 1, 1'b0);
        run_access("both_set", 1'b1, 1'b1, 32'h0000_0300, 32'h1111_2222, 32'h3333_4444, 3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            int          kind;
            int          lat;
            a    = $urandom;
            if ($urandom_range(0, 99) < 85) a[1:0] = 2'b00;
            kind = $urandom_range(0, 3);
            lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            run_access("rand", kind == 2 || kind == 3, kind == 1 || kind == 3, a, $urandom,
                       $urandom, lat, 1'($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
